// File: rtl/param_register_file.sv
// Parametrised bank of FunSel registers: shared input bus and opcode, per-register
// enables, two combinational read ports and registered per-register Zero/Carry flags.
module param_register_file #(
  parameter int              WIDTH       = 16,
  parameter int              NREGS       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int             SELW        = $clog2(NREGS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [WIDTH-1:0]  I,
  input  logic [3:0]        FunSel,
  input  logic [NREGS-1:0]  E,
  input  logic [SELW-1:0]   SelA,
  input  logic [SELW-1:0]   SelB,
  output logic [WIDTH-1:0]  QA,
  output logic [WIDTH-1:0]  QB,
  output logic [NREGS-1:0]  Z,
  output logic [NREGS-1:0]  C
);

  localparam int HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [3:0] {
    OP_DEC   = 4'b0000,
    OP_INC   = 4'b0001,
    OP_LOAD  = 4'b0010,
    OP_CLR   = 4'b0011,
    OP_LOZ   = 4'b0100,
    OP_LOK   = 4'b0101,
    OP_HIL   = 4'b0110,
    OP_SEXT  = 4'b0111,
    OP_LSL   = 4'b1000,
    OP_LSR   = 4'b1001,
    OP_ASR   = 4'b1010,
    OP_ROL   = 4'b1011,
    OP_ROR   = 4'b1100,
    OP_NOT   = 4'b1101,
    OP_SWAP  = 4'b1110,
    OP_HOLD  = 4'b1111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] nxt  [NREGS];
  logic [NREGS-1:0] nz;
  logic [NREGS-1:0] nc;

  assign op = op_e'(FunSel);

  // Every register computes its candidate value from its own current contents.
  always_comb begin
    for (int unsigned k = 0; k < NREGS; k++) begin
      nxt[k] = regs[k];
      nc[k]  = 1'b0;
      unique case (op)
        OP_DEC:  begin nxt[k] = regs[k] - ONE; nc[k] = (regs[k] == '0); end
        OP_INC:  begin nxt[k] = regs[k] + ONE; nc[k] = (regs[k] == '1); end
        OP_LOAD: nxt[k] = I;
        OP_CLR:  nxt[k] = '0;
        OP_LOZ:  nxt[k] = {{HALF{1'b0}}, I[HALF-1:0]};
        OP_LOK:  nxt[k] = {regs[k][WIDTH-1:HALF], I[HALF-1:0]};
        OP_HIL:  nxt[k] = {I[HALF-1:0], regs[k][HALF-1:0]};
        OP_SEXT: nxt[k] = {{HALF{I[HALF-1]}}, I[HALF-1:0]};
        OP_LSL:  begin nxt[k] = {regs[k][WIDTH-2:0], 1'b0}; nc[k] = regs[k][WIDTH-1]; end
        OP_LSR:  begin nxt[k] = {1'b0, regs[k][WIDTH-1:1]}; nc[k] = regs[k][0]; end
        OP_ASR:  begin nxt[k] = {regs[k][WIDTH-1], regs[k][WIDTH-1:1]}; nc[k] = regs[k][0]; end
        OP_ROL:  begin nxt[k] = {regs[k][WIDTH-2:0], regs[k][WIDTH-1]}; nc[k] = regs[k][WIDTH-1]; end
        OP_ROR:  begin nxt[k] = {regs[k][0], regs[k][WIDTH-1:1]}; nc[k] = regs[k][0]; end
        OP_NOT:  nxt[k] = ~regs[k];
        OP_SWAP: nxt[k] = {regs[k][HALF-1:0], regs[k][WIDTH-1:HALF]};
        default: nxt[k] = regs[k];
      endcase
      nz[k] = (nxt[k] == '0);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned k = 0; k < NREGS; k++) regs[k] <= RESET_VALUE;
      Z <= '0;
      C <= '0;
    end else begin
      for (int unsigned k = 0; k < NREGS; k++) begin
        if (E[k] && (op != OP_HOLD)) begin
          regs[k] <= nxt[k];
          Z[k]    <= nz[k];
          C[k]    <= nc[k];
        end
      end
    end
  end

  // Selects beyond the last register (non-power-of-two banks) read as zero.
  always_comb begin
    QA = '0;
    QB = '0;
    if (int'(SelA) < NREGS) QA = regs[SelA];
    if (int'(SelB) < NREGS) QB = regs[SelB];
  end

endmodule

// File: tb/tb_param_register_file.sv
// Directed-vector bench for param_register_file: an arithmetic model of the default
// 16x4 bank is compared every cycle, with literal spot checks and an 8-bit/3-reg instance.
module tb_param_register_file;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] I;
  logic [3:0]  FunSel;
  logic [3:0]  E;
  logic [1:0]  SelA, SelB;
  logic [15:0] QA, QB;
  logic [3:0]  Z, C;

  logic [7:0]  s_I;
  logic [2:0]  s_E;
  logic [1:0]  s_SelA, s_SelB;
  logic [7:0]  s_QA, s_QB;
  logic [2:0]  s_Z, s_C;

  int errors = 0;
  int checks = 0;

  int m  [4];
  int mz [4];
  int mc [4];
  bit model_valid = 1'b0;

  always #5 Clock = ~Clock;

  param_register_file dut (
    .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .E(E),
    .SelA(SelA), .SelB(SelB), .QA(QA), .QB(QB), .Z(Z), .C(C)
  );

  param_register_file #(.WIDTH(8), .NREGS(3), .RESET_VALUE(8'h7F)) dut_small (
    .Clock(Clock), .Reset(Reset), .I(s_I), .FunSel(FunSel), .E(s_E),
    .SelA(s_SelA), .SelB(s_SelB), .QA(s_QA), .QB(s_QB), .Z(s_Z), .C(s_C)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode semantics written as plain integer arithmetic on a 16-bit value.
  function automatic void model_op(input int r, input int fs, input int d, output int nv, output int c);
    int lo;
    lo = d % 256;
    c  = 0;
    case (fs)
      0:  begin nv = (r + 65535) % 65536; c = (r == 0); end
      1:  begin nv = (r + 1) % 65536;     c = (r == 65535); end
      2:  nv = d;
      3:  nv = 0;
      4:  nv = lo;
      5:  nv = (r / 256) * 256 + lo;
      6:  nv = lo * 256 + r % 256;
      7:  nv = lo + ((lo >= 128) ? 65280 : 0);
      8:  begin nv = (r * 2) % 65536; c = (r >= 32768); end
      9:  begin nv = r / 2; c = r % 2; end
      10: begin nv = r / 2 + ((r >= 32768) ? 32768 : 0); c = r % 2; end
      11: begin nv = (r * 2) % 65536 + r / 32768; c = (r >= 32768); end
      12: begin nv = r / 2 + (r % 2) * 32768; c = r % 2; end
      13: nv = 65535 - r;
      14: nv = (r % 256) * 256 + r / 256;
      default: nv = r;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < 4; k++) begin m[k] <= 0; mz[k] <= 0; mc[k] <= 0; end
      model_valid <= 1'b1;
    end else if (model_valid) begin
      for (int k = 0; k < 4; k++) begin
        if (E[k] && FunSel != 4'hF) begin
          int nv, c;
          model_op(m[k], int'(FunSel), int'(I), nv, c);
          m[k]  <= nv;
          mz[k] <= (nv == 0);
          mc[k] <= c;
        end
      end
    end
  end

  always @(negedge Clock) begin
    if (model_valid) begin
      chk("QA vs model", 32'(QA), 32'(m[SelA]));
      chk("QB vs model", 32'(QB), 32'(m[SelB]));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("Z[%0d] vs model", k), 32'(Z[k]), 32'(mz[k]));
        chk($sformatf("C[%0d] vs model", k), 32'(C[k]), 32'(mc[k]));
      end
    end
  end

  task automatic step(input logic [3:0] fs, input logic [3:0] e, input logic [15:0] d);
    FunSel = fs; E = e; I = d;
    @(posedge Clock); #1;
    E = '0; FunSel = 4'hF;
  endtask

  task automatic rd(input string name, input logic [1:0] sel, input logic [15:0] exp);
    SelA = sel; #1;
    chk(name, 32'(QA), 32'(exp));
  endtask

  initial begin
    Reset = 1'b1; FunSel = 4'hF; E = '0; I = '0; SelA = '0; SelB = '0;
    s_I = '0; s_E = '0; s_SelA = '0; s_SelB = '0;
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b0;
    chk("reset Z", 32'(Z), 32'h0);
    chk("reset C", 32'(C), 32'h0);
    rd("reset R0", 2'd0, 16'h0000);
    rd("reset R3", 2'd3, 16'h0000);

    // Small instance: reset value, sign-extend, out-of-range select.
    s_SelA = 2'd0; s_SelB = 2'd2; #1;
    chk("small reset R0", 32'(s_QA), 32'h7F);
    chk("small reset R2", 32'(s_QB), 32'h7F);
    chk("small reset Z", 32'(s_Z), 32'h0);
    s_I = 8'h0A; s_E = 3'b001; FunSel = 4'b0111;
    @(posedge Clock); #1;
    s_E = '0; FunSel = 4'hF;
    s_SelA = 2'd0; #1;
    chk("small sext", 32'(s_QA), 32'hFA);
    chk("small Z after sext", 32'(s_Z), 32'h0);
    s_SelA = 2'd3; #1;
    chk("small sel oob", 32'(s_QA), 32'h00);

    // Broadcast load, hold, then reset overrides a load.
    step(4'b0010, 4'b1111, 16'hA5C3);
    step(4'b1111, 4'b1111, 16'h0000);
    rd("load R0", 2'd0, 16'hA5C3);
    rd("load R2", 2'd2, 16'hA5C3);
    chk("load Z", 32'(Z), 32'h0);
    Reset = 1'b1;
    step(4'b0010, 4'b1111, 16'h1234);
    Reset = 1'b0;
    rd("reset over load R1", 2'd1, 16'h0000);
    chk("model after reset", 32'(m[1]), 32'h0);

    // Wrap-around on R0.
    step(4'b0010, 4'b0001, 16'hFFFF);
    step(4'b0001, 4'b0001, 16'h0000);
    rd("inc wrap", 2'd0, 16'h0000);
    chk("inc wrap Z0", 32'(Z[0]), 32'h1);
    chk("inc wrap C0", 32'(C[0]), 32'h1);
    step(4'b0000, 4'b0001, 16'h0000);
    rd("dec wrap", 2'd0, 16'hFFFF);
    chk("dec wrap flags", 32'({Z[0], C[0]}), 32'b01);
    chk("model dec wrap", 32'(m[0]), 32'hFFFF);

    // Half loads on R2.
    step(4'b0010, 4'b0100, 16'hABCD);
    step(4'b0101, 4'b0100, 16'h12F0); rd("half 0101", 2'd2, 16'hABF0);
    step(4'b0110, 4'b0100, 16'h12F0); rd("half 0110", 2'd2, 16'hF0F0);
    step(4'b0100, 4'b0100, 16'h12F0); rd("half 0100", 2'd2, 16'h00F0);
    step(4'b0111, 4'b0100, 16'h12F0); rd("half 0111", 2'd2, 16'hFFF0);

    // Shifts and rotates on R3 = 0x8001.
    for (int n = 0; n < 5; n++) begin
      logic [3:0]  fs_tab  [5];
      logic [15:0] exp_tab [5];
      fs_tab  = '{4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};
      exp_tab = '{16'h0002, 16'h4000, 16'hC000, 16'h0003, 16'hC000};
      step(4'b0010, 4'b1000, 16'h8001);
      step(fs_tab[n], 4'b1000, 16'h0000);
      rd($sformatf("shift op %b", fs_tab[n]), 2'd3, exp_tab[n]);
      chk($sformatf("shift op %b C3", fs_tab[n]), 32'(C[3]), 32'h1);
    end
    step(4'b0010, 4'b1000, 16'hFFFF);
    step(4'b1101, 4'b1000, 16'h0000);
    rd("not", 2'd3, 16'h0000);
    chk("not flags", 32'({Z[3], C[3]}), 32'b10);
    step(4'b0010, 4'b1000, 16'h12AB);
    step(4'b1110, 4'b1000, 16'h0000);
    rd("swap", 2'd3, 16'hAB12);

    // Multi-enable with pre/post-edge reads.
    step(4'b0010, 4'b0001, 16'd5);
    step(4'b0010, 4'b0010, 16'd9);
    FunSel = 4'b0001; E = 4'b0011; SelA = 2'd0; SelB = 2'd1; #1;
    chk("multi pre QA", 32'(QA), 32'd5);
    chk("multi pre QB", 32'(QB), 32'd9);
    @(posedge Clock); #1;
    E = '0; FunSel = 4'hF;
    chk("multi post QA", 32'(QA), 32'd6);
    chk("multi post QB", 32'(QB), 32'd10);
    SelA = 2'd2; SelB = 2'd2; #1;
    chk("same sel QA", 32'(QA), 32'hFFF0);
    chk("same sel QB", 32'(QB), 32'hFFF0);
    @(posedge Clock); @(negedge Clock); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
